input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 1000000, giving the number of consecutive cycles a synchronized input must differ from its stable value before the stable value changes (10 ms at 100 MHz).
REQ-002 The module SHALL have parameter REPEAT_DELAY, default 50000000, giving the cycles from a debounced press to the first auto-repeat pulse.
REQ-003 The module SHALL have parameter REPEAT_PERIOD, default 10000000, giving the cycles between later auto-repeat pulses.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port usr_btn, input, 4 bits: raw asynchronous push buttons, active-high.
REQ-007 The module SHALL have port usr_sw, input, 4 bits: raw asynchronous slide switches.
REQ-008 The module SHALL have port btn_level, output, 4 bits: debounced button levels.
REQ-009 The module SHALL have port btn_press, output, 4 bits: one-cycle pulse per debounced press (and per repeat when enabled).
REQ-010 The module SHALL have port btn_release, output, 4 bits: one-cycle pulse per debounced release.
REQ-011 The module SHALL have port sw_level, output, 4 bits: debounced switch levels.
REQ-012 The module SHALL have port sw_change, output, 4 bits: one-cycle pulse on any debounced switch transition.
REQ-013 The module SHALL have port ready, output, 1 bit: high once the initialization phase has completed.

Function
REQ-014 The module SHALL pass each of the 8 raw inputs through a 2-flop synchronizer before any other use.
REQ-015 Each input SHALL have an independent debounce counter, wide enough for DEB_CYCLES-1: the counter increments on each cycle the synchronized value differs from the stable value, and clears to 0 on any cycle they match.
REQ-016 When the synchronized value differs from the stable value and the counter equals DEB_CYCLES-1, the stable value SHALL take the synchronized value and the counter SHALL clear, so the latency from a raw edge to a level change is DEB_CYCLES+2 cycles.
REQ-017 A glitch shorter than DEB_CYCLES synchronized cycles SHALL produce no level change and no pulse.
REQ-018 The btn_press, btn_release and sw_change pulses SHALL be high in exactly the first cycle in which the new level is visible on btn_level or sw_level.
REQ-019 The FSM SHALL have states ST_INIT and ST_RUN; ST_INIT SHALL last 3 cycles after reset deasserts.
REQ-020 On the last ST_INIT cycle, the sw stable values SHALL load directly from the synchronizers with no sw_change pulse, and the FSM SHALL then enter ST_RUN with ready=1.
REQ-021 In ST_INIT, the module SHALL hold all counters at 0, hold all pulses low, and hold btn stable values at 0.
REQ-022 The FSM SHALL stay in ST_RUN until reset.
REQ-023 Bits SHALL be fully independent, so simultaneous transitions on several inputs SHALL produce simultaneous pulses.
REQ-024 No debounce counter SHALL wrap; each counter saturates by construction through REQ-015 and REQ-016.

Reset
REQ-025 When reset=1 at a clk edge, the FSM SHALL go to ST_INIT and all synchronizer flops, counters, stable values and outputs SHALL become 0, including ready=0.
REQ-026 A reset asserted mid-debounce or mid-repeat SHALL abandon that operation with no pulse emitted.

Configuration
REQ-027 With AUTO_REPEAT_EN defined, each button SHALL have a repeat counter that runs while btn_level is 1.
REQ-028 With AUTO_REPEAT_EN defined, btn_press SHALL additionally pulse REPEAT_DELAY cycles after the debounced press, and then every REPEAT_PERIOD cycles until release.
REQ-029 With AUTO_REPEAT_EN defined, release SHALL clear the repeat counter and stop further repeats immediately.
REQ-030 Without AUTO_REPEAT_EN, the module SHALL have no repeat logic and SHALL emit exactly one btn_press per debounced press.

Verification (DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-031 The bench SHALL cover: reset held 5 cycles with usr_sw=4'b0101 -> ready rises on the 4th cycle after deassert, sw_level=4'b0101, and sw_change stays 0.
REQ-032 The bench SHALL cover: usr_btn[0] rises at cycle T and is held -> btn_level[0] and btn_press[0] are both 1 at cycle T+6, and btn_press[0] is 0 at T+7.
REQ-033 The bench SHALL cover: usr_btn[2] pulsed high for 3 cycles -> btn_level, btn_press and btn_release all stay 0.
REQ-034 The bench SHALL cover: usr_btn[1] and usr_sw[3] toggled in the same cycle -> btn_press[1] and sw_change[3] pulse in the same cycle; on release, btn_release[1] pulses once.
REQ-035 The bench SHALL cover, with AUTO_REPEAT_EN: usr_btn[3] held for 30 cycles after its debounced press -> btn_press[3] pulses at offsets 0, 10, 15, 20 and 25; without the macro, only offset 0.
REQ-036 The bench SHALL cover: reset asserted while the usr_btn[0] counter is at 2 -> no pulse, and all outputs read 0 on the next cycle.

Source files
------------

// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects 4 push buttons and 4 slide switches.
// Define AUTO_REPEAT_EN to add hold-to-repeat press pulses on the buttons.
module input_conditioner #(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] usr_btn,
    input  logic [3:0] usr_sw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic [3:0] sw_level,
    output logic [3:0] sw_change,
    output logic       ready
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    state_t                state_q, state_d;
    logic [1:0]            init_cnt_q, init_cnt_d;
    logic [7:0]            sync1_q, sync2_q;
    logic [7:0]            stab_q, stab_d;
    logic [7:0][DW-1:0]    cnt_q, cnt_d;
    logic [3:0]            press_q, press_d;
    logic [3:0]            release_q, release_d;
    logic [3:0]            swchg_q, swchg_d;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [3:0][RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [3:0]         rep_arm_q, rep_arm_d;
`else
    // Repeat timing has no consumer when auto-repeat is compiled out.
    localparam int unsigned unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;
`endif

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        stab_d     = stab_q;
        cnt_d      = cnt_q;
        press_d    = '0;
        release_d  = '0;
        swchg_d    = '0;
        unique case (state_q)
            ST_INIT: begin
                stab_d[3:0] = '0;
                cnt_d       = '0;
                if (init_cnt_q == 2'd2) begin
                    state_d     = ST_RUN;
                    stab_d[7:4] = sync2_q[7:4];
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            ST_RUN: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    if (sync2_q[i] != stab_q[i]) begin
                        if (cnt_q[i] == DEB_LAST) begin
                            stab_d[i] = sync2_q[i];
                            cnt_d[i]  = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + DW'(1);
                        end
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                press_d   = stab_d[3:0] & ~stab_q[3:0];
                release_d = ~stab_d[3:0] & stab_q[3:0];
                swchg_d   = stab_d[7:4] ^ stab_q[7:4];
            end
            default: ;
        endcase

`ifdef AUTO_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
        rep_arm_d = rep_arm_q;
        // Repeats only while the level stays high across the edge, so a release wins.
        for (int unsigned b = 0; b < 4; b++) begin
            if (state_q == ST_RUN && stab_q[b] && stab_d[b]) begin
                if (rep_cnt_q[b] == (rep_arm_q[b] ? PER_LAST : DLY_LAST)) begin
                    rep_cnt_d[b] = '0;
                    rep_arm_d[b] = 1'b1;
                    press_d[b]   = 1'b1;
                end else begin
                    rep_cnt_d[b] = rep_cnt_q[b] + RW'(1);
                end
            end else begin
                rep_cnt_d[b] = '0;
                rep_arm_d[b] = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            stab_q     <= '0;
            cnt_q      <= '0;
            press_q    <= '0;
            release_q  <= '0;
            swchg_q    <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q  <= '0;
            rep_arm_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sync1_q    <= {usr_sw, usr_btn};
            sync2_q    <= sync1_q;
            stab_q     <= stab_d;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            swchg_q    <= swchg_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
            rep_arm_q  <= rep_arm_d;
`endif
        end
    end

    assign btn_level   = stab_q[3:0];
    assign sw_level    = stab_q[7:4];
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign sw_change   = swchg_q;
    assign ready       = (state_q == ST_RUN);

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random stimulus against a
// sample-history reference model; honours AUTO_REPEAT_EN like the design.
module tb_input_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 5;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = '0;
    logic [3:0] sw  = '0;
    logic [3:0] btn_level, btn_press, btn_release, sw_level, sw_change;
    logic       ready;

    int n_checks = 0;
    int n_fail   = 0;

    input_conditioner #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .usr_btn    (btn),
        .usr_sw     (sw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_level   (sw_level),
        .sw_change  (sw_change),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Reference model state: raw inputs delayed two edges, per-input sample history.
    logic [7:0] m_d1, m_d2;
    logic [3:0] m_btn, m_sw, m_press, m_rel, m_chg;
    bit         m_ready;
    int         m_init;
    bit         hist[8][$];
    int         age[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [7:0] smp;
        logic       cur;
        bit         all_diff;
        bit         was;
        int         n;
        m_press = '0;
        m_rel   = '0;
        m_chg   = '0;
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_btn = '0; m_sw = '0;
            m_ready = 0; m_init = 0;
            for (int i = 0; i < 8; i++) hist[i].delete();
            for (int b = 0; b < 4; b++) age[b] = -1;
            return;
        end
        smp = m_d2;
        if (!m_ready) begin
            m_init++;
            if (m_init == 3) begin
                m_ready = 1;
                m_sw    = smp[7:4];
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                cur = (i < 4) ? m_btn[i] : m_sw[i-4];
                hist[i].push_back(smp[i]);
                while (hist[i].size() > DEB) void'(hist[i].pop_front());
                n = hist[i].size();
                all_diff = (n == DEB);
                for (int k = 0; k < n; k++) if (hist[i][k] == cur) all_diff = 0;
                if (all_diff) begin
                    hist[i].delete();
                    if (i < 4) begin
                        m_btn[i] = ~cur;
                        if (!cur) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
                    end else begin
                        m_sw[i-4]  = ~cur;
                        m_chg[i-4] = 1'b1;
                    end
                end
            end
            for (int b = 0; b < 4; b++) begin
                was = m_press[b];
                if (was) age[b] = 0;
                else if (!m_btn[b]) age[b] = -1;
                else if (age[b] >= 0) begin
                    age[b]++;
                    if (AR && (age[b] == RD || (age[b] > RD && (age[b] - RD) % RP == 0)))
                        m_press[b] = 1'b1;
                end
            end
        end
        m_d2 = m_d1;
        m_d1 = {sw, btn};
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("btn_level",   32'(btn_level),   32'(m_btn));
        check("btn_press",   32'(btn_press),   32'(m_press));
        check("btn_release", 32'(btn_release), 32'(m_rel));
        check("sw_level",    32'(sw_level),    32'(m_sw));
        check("sw_change",   32'(sw_change),   32'(m_chg));
        check("ready",       32'(ready),       32'(m_ready));
    endtask

    initial begin : main
        logic [31:0] mask;
        int          rel_cnt;
        int          waited;

        // Power-up: reset held 5 cycles with switches at 0101.
        rst = 1'b1; sw = 4'b0101; btn = '0;
        repeat (5) step();
        rst = 1'b0;
        step(); check("init_ready_c1", 32'(ready), 32'd0);
        step(); check("init_ready_c2", 32'(ready), 32'd0);
        step();
        check("init_ready_c4", 32'(ready), 32'd1);
        check("init_sw_level", 32'(sw_level), 32'h5);
        check("init_sw_chg",   32'(sw_change), 32'h0);
        repeat (2) step();

        // Single press: level and press both appear 6 edges after the raw edge.
        btn[0] = 1'b1;
        repeat (5) step();
        check("press0_early", 32'(btn_level[0]), 32'd0);
        step();
        check("press0_level", 32'(btn_level[0]), 32'd1);
        check("press0_pulse", 32'(btn_press[0]), 32'd1);
        step();
        check("press0_once",  32'(btn_press[0]), 32'd0);
        repeat (3) step();
        btn[0] = 1'b0;
        repeat (8) step();

        // Glitch shorter than the debounce window.
        btn[2] = 1'b1;
        repeat (3) step();
        btn[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("glitch2", 32'({btn_level[2], btn_press[2], btn_release[2]}), 32'd0);
        end

        // Simultaneous button and switch transitions.
        btn[1] = 1'b1; sw[3] = 1'b1;
        repeat (6) step();
        check("simul_press1", 32'(btn_press[1]), 32'd1);
        check("simul_chg3",   32'(sw_change[3]), 32'd1);
        btn[1] = 1'b0;
        rel_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            rel_cnt += int'(btn_release[1]);
        end
        check("release1_count", 32'(rel_cnt), 32'd1);

        // Hold button 3 for 30 cycles after its debounced press and record press pulses.
        btn[3] = 1'b1;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!btn_press[3] && waited < 20);
        check("hold3_seen", 32'(btn_press[3]), 32'd1);
        mask = 32'd1;
        for (int k = 1; k < 30; k++) begin
            step();
            mask[k] = btn_press[3];
        end
        check("hold3_offsets", mask, AR ? 32'h0210_8401 : 32'h0000_0001);
        btn[3] = 1'b0;
        repeat (8) step();

        // Reset in the middle of a debounce.
        btn[0] = 1'b1;
        repeat (4) step();
        rst = 1'b1; btn[0] = 1'b0;
        step();
        check("midreset_outs",
              32'({btn_level, btn_press, btn_release, sw_level, sw_change, ready}), 32'd0);
        rst = 1'b0;
        repeat (4) step();

        // Random phase: slowly varying inputs so both glitches and real edges occur.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) sw[$urandom_range(0, 3)]  ^= 1'b1;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
